// File: rtl/seg7_pkg.sv
// seg7_pkg: active-high glyphs, converter FSM states and BCD sizing helper
package seg7_pkg;
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

    // decimal digits needed to hold 2^w-1
    function automatic int bcd_nibbles(input int w);
        longint v;
        int n;
        v = (longint'(1) << w) - 1;
        n = 0;
        while (v > 0) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction
endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: BCD nibble to active-high {g,f,e,d,c,b,a} glyph
//   nib_i   : BCD digit 0..9 (other codes give all segments off)
//   glyph_o : active-high segment pattern
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);
    always_comb begin
        case (nib_i)
            4'd0:    glyph_o = SEG_0;
            4'd1:    glyph_o = SEG_1;
            4'd2:    glyph_o = SEG_2;
            4'd3:    glyph_o = SEG_3;
            4'd4:    glyph_o = SEG_4;
            4'd5:    glyph_o = SEG_5;
            4'd6:    glyph_o = SEG_6;
            4'd7:    glyph_o = SEG_7;
            4'd8:    glyph_o = SEG_8;
            4'd9:    glyph_o = SEG_9;
            default: glyph_o = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seven_segment_scan_bcd.sv
// seven_segment_scan_bcd: sequential binary-to-BCD converter and multiplexed 7-segment scanner
//   CLOCK/RESET         : rising-edge clock, synchronous active-high reset
//   TICK                : refresh enable advancing digit index and blink counter
//   VALUE/LOAD          : binary value and conversion start (queued while BUSY)
//   BLANK_LZ            : leading-zero blanking enable
//   BLINK_MASK/DP_MASK  : per-digit blink and decimal point, bit 0 = leftmost
//   BUSY/OVERFLOW       : conversion running / value >= 10^DIGITS
//   SEVEN_SEG_OUT/DP_OUT/anodes : registered pin drivers, polarity per parameters
module seven_segment_scan_bcd
    import seg7_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int VALUE_W          = 14,
    parameter int BLINK_DIV        = 500,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               TICK,
    input  logic [VALUE_W-1:0] VALUE,
    input  logic               LOAD,
    input  logic               BLANK_LZ,
    input  logic [DIGITS-1:0]  BLINK_MASK,
    input  logic [DIGITS-1:0]  DP_MASK,
    output logic               BUSY,
    output logic               OVERFLOW,
    output logic [6:0]         SEVEN_SEG_OUT,
    output logic               DP_OUT,
    output logic [DIGITS-1:0]  anodes
);
    localparam int NEED = bcd_nibbles(VALUE_W);
    // always keep at least one guard nibble so the overflow slice is never empty
    localparam int NIB  = NEED > DIGITS ? NEED : DIGITS + 1;
    localparam int IW   = $clog2(DIGITS);
    localparam int BW   = $clog2(BLINK_DIV + 1);
    localparam int CW   = $clog2(VALUE_W + 1);
    localparam logic [DIGITS-1:0] AN_POL = {DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [VALUE_W-1:0]   bin_q, bin_d, pend_q, pend_d;
    logic [4*NIB-1:0]     bcd_q, bcd_d, adj;
    logic [4*DIGITS-1:0]  disp_q, disp_d;
    logic                 pend_v_q, pend_v_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic                 phase_q, phase_d, blink_wrap;
    logic [3:0]           nib;
    logic [6:0]           glyph, seg_hi;
    logic [DIGITS-1:0]    an_hi;
    logic                 lead, bm, dm, blank;

    always_comb begin
        adj = bcd_q;
        for (int n = 0; n < NIB; n++)
            if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        disp_d   = disp_q;
        busy_d   = state_q != S_IDLE || LOAD;
        if (LOAD && state_q != S_IDLE) begin
            pend_d   = VALUE;
            pend_v_d = 1'b1;
        end
        case (state_q)
            S_IDLE: if (LOAD) begin
                state_d = S_SHIFT;
                bin_d   = VALUE;
                bcd_d   = '0;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(VALUE_W - 1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                ovf_d  = |bcd_q[4*NIB-1:4*DIGITS];
                disp_d = bcd_q[4*DIGITS-1:0];
                state_d = S_IDLE;
                // a LOAD in this very cycle is newer than anything pending
                if (LOAD || pend_v_q) begin
                    state_d  = S_SHIFT;
                    bin_d    = LOAD ? VALUE : pend_q;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    pend_v_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blink_wrap = TICK && bcnt_q == BW'(BLINK_DIV - 1);
        idx_d   = TICK ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
        bcnt_d  = blink_wrap ? '0 : (TICK ? bcnt_q + BW'(1) : bcnt_q);
        phase_d = phase_q ^ blink_wrap;
        nib   = '0;
        lead  = 1'b1;
        bm    = 1'b0;
        dm    = 1'b0;
        an_hi = '0;
        // nibble DIGITS-1-k belongs to digit k, since digit 0 is the most significant
        for (int k = 0; k < DIGITS; k++) begin
            if (k <= int'(idx_q) && disp_q[4*(DIGITS-1-k) +: 4] != 4'd0) lead = 1'b0;
            if (k == int'(idx_q)) begin
                nib      = disp_q[4*(DIGITS-1-k) +: 4];
                bm       = BLINK_MASK[k];
                dm       = DP_MASK[k];
                an_hi[k] = 1'b1;
            end
        end
        blank  = (BLANK_LZ && !ovf_q && lead && idx_q != IW'(DIGITS - 1)) || (!phase_q && bm);
        seg_hi = blank ? SEG_OFF : (ovf_q ? SEG_DASH : glyph);
    end

    seg7_glyph_rom u_rom (
        .nib_i   (nib),
        .glyph_o (glyph)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bin_q         <= '0;
            bcd_q         <= '0;
            pend_q        <= '0;
            pend_v_q      <= 1'b0;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
            disp_q        <= '0;
            idx_q         <= '0;
            bcnt_q        <= '0;
            phase_q       <= 1'b1;
            SEVEN_SEG_OUT <= SEG_OFF ^ SEG_POL;
            DP_OUT        <= SEG_ACTIVE_LOW;
            anodes        <= AN_POL;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            pend_q        <= pend_d;
            pend_v_q      <= pend_v_d;
            busy_q        <= busy_d;
            ovf_q         <= ovf_d;
            disp_q        <= disp_d;
            idx_q         <= idx_d;
            bcnt_q        <= bcnt_d;
            phase_q       <= phase_d;
            SEVEN_SEG_OUT <= seg_hi ^ SEG_POL;
            DP_OUT        <= (!blank && dm) ^ SEG_ACTIVE_LOW;
            anodes        <= (blank ? '0 : an_hi) ^ AN_POL;
        end
    end

    assign BUSY     = busy_q;
    assign OVERFLOW = ovf_q;
endmodule

// File: tb/tb_seven_segment_scan_bcd.sv
// tb_seven_segment_scan_bcd: randomized and directed checks against a decimal-arithmetic display model
module tb_seven_segment_scan_bcd;
    localparam int D   = 4;
    localparam int W   = 14;
    localparam int BD  = 4;
    localparam int MOD = 10000;

    logic         clk, rst, tick, load, blz, busy, ovf, dp;
    logic [W-1:0] value;
    logic [D-1:0] bmask, dmask, an;
    logic [6:0]   seg;

    int checks = 0;
    int errors = 0;

    seven_segment_scan_bcd #(.DIGITS(D), .VALUE_W(W), .BLINK_DIV(BD)) dut (
        .CLOCK(clk), .RESET(rst), .TICK(tick), .VALUE(value), .LOAD(load),
        .BLANK_LZ(blz), .BLINK_MASK(bmask), .DP_MASK(dmask), .BUSY(busy),
        .OVERFLOW(ovf), .SEVEN_SEG_OUT(seg), .DP_OUT(dp), .anodes(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p *= 10;
        return p;
    endfunction

    logic [6:0] gly [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

    // reference: display held as a decimal number, commits timed from the LOAD that started them
    int   m_disp, m_cv, m_pend, m_left, m_t, slot, pw;
    bit   m_ovf, m_pv, m_tail, m_valid, ph_on, lzb, blk;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;

    initial m_valid = 0;

    always begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1; m_disp = 0; m_ovf = 0; m_left = 0; m_pv = 0; m_tail = 0; m_t = 0;
            e_seg = 7'h7f; e_an = 4'hf; e_dp = 1'b1;
        end else begin
            slot  = m_t % D;
            ph_on = ((m_t / BD) % 2) == 0;
            pw    = pow10(D - 1 - slot);
            lzb   = blz && !m_ovf && slot != D - 1 && (m_disp / pw) == 0;
            blk   = lzb || (!ph_on && bmask[slot]);
            e_seg = ~(blk ? 7'h00 : (m_ovf ? 7'h40 : gly[(m_disp / pw) % 10]));
            e_an  = blk ? 4'hf : ~(4'b0001 << slot);
            e_dp  = ~(!blk && dmask[slot]);
            if (tick) m_t++;
            m_tail = 0;
            if (m_left == 1) begin
                m_disp = m_cv % MOD;
                m_ovf  = m_cv >= MOD;
                if (load || m_pv) begin
                    m_cv = load ? int'(value) : m_pend;
                    m_left = W + 1;
                    m_pv = 0;
                end else begin
                    m_left = 0;
                    m_tail = 1;
                end
            end else if (m_left > 1) begin
                if (load) begin m_pend = int'(value); m_pv = 1; end
                m_left--;
            end else if (load) begin
                m_cv = int'(value);
                m_left = W + 1;
            end
        end
        #1;
        if (m_valid) begin
            check("seg", seg, e_seg);
            check("anodes", an, e_an);
            check("dp", dp, e_dp);
            check("busy", busy, m_left > 0 || m_tail);
            check("overflow", ovf, m_ovf);
        end
    end

    task automatic cyc(input bit ld, input int v, input bit tk);
        load  = ld;
        value = W'(v);
        tick  = tk;
        @(negedge clk);
    endtask

    task automatic show(input int slots);
        for (int i = 0; i < slots; i++) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 60 && busy; i++) cyc(0, 0, 0);
        check("settle", busy, 1'b0);
    endtask

    int n;

    initial begin
        rst = 1; load = 0; tick = 0; value = '0; blz = 0; bmask = '0; dmask = '0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hf);
        check("rst_seg", seg, 7'h7f);
        rst = 0;
        cyc(1, 1234, 0);
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin n++; cyc(0, 0, 0); end
        check("busy_len", n, W + 2);
        show(4);
        blz = 1;
        cyc(1, 7, 0); settle(); show(4);
        cyc(1, 0, 0); settle(); show(4);
        blz = 0;
        cyc(1, 12345, 0); settle();
        check("ovf_set", ovf, 1'b1);
        show(4);
        cyc(1, 9999, 0); settle();
        check("ovf_clr", ovf, 1'b0);
        show(4);
        bmask = 4'b0011; dmask = 4'b0100;
        repeat (24) cyc(0, 0, 1);
        bmask = '0; dmask = '0;
        cyc(1, 1111, 0);
        n = 0;
        for (int c = 1; c < 80 && busy; c++) begin
            n++;
            cyc(c == 5 || c == 8, c == 5 ? 2222 : 3333, c[0]);
        end
        check("busy_chain", n, 2 * (W + 1) + 1);
        show(4);
        cyc(1, 5678, 0);
        repeat (4) cyc(0, 0, 0);
        rst = 1; cyc(1, 4321, 0); rst = 0;
        check("rst_busy", busy, 1'b0);
        check("rst_mid_an", an, 4'hf);
        show(4);
        blz = 1; show(4);
        for (int i = 0; i < 3000; i++) begin
            int v;
            case ($urandom % 6)
                0: v = 0;
                1: v = 9999;
                2: v = 10000;
                3: v = 16383;
                4: v = $urandom % 100;
                default: v = $urandom % 16384;
            endcase
            if ($urandom % 50 == 0) blz = $urandom % 2;
            if ($urandom % 50 == 0) bmask = D'($urandom);
            if ($urandom % 50 == 0) dmask = D'($urandom);
            rst = ($urandom % 400) == 0;
            cyc(($urandom % 16) == 0, v, $urandom % 2);
        end
        rst = 0;
        cyc(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_segment_scan_bcd.md
Name: seven_segment_scan_bcd

Overview:
- Parametrised N-digit multiplexed 7-segment driver for the alarm-clock and stopwatch display paths.
- Converts a binary value to BCD with a sequential shift-add-3 FSM, so no combinational divide or modulo is needed.
- Scans the digits on an external refresh tick and adds leading-zero blanking, per-digit blink, per-digit decimal point and overflow indication.
- Sits between the time/stopwatch counters and the board anode/segment pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- VALUE_W, 14, width of the binary input value.
- BLINK_DIV, 500, refresh ticks per blink half-period (500 ticks × 1 ms = 0.5 s).
- ANODE_ACTIVE_LOW, 1, 1 = anode enable is driven 0.
- SEG_ACTIVE_LOW, 1, 1 = a lit segment is driven 0; also applies to DP_OUT.

Ports:
- CLOCK, input, 1, system clock; all logic is on the rising edge.
- RESET, input, 1, synchronous, active-high reset.
- TICK, input, 1, one-CLOCK-wide refresh enable (nominally 1 ms).
- VALUE, input, VALUE_W, binary value to display.
- LOAD, input, 1, sample VALUE and start a conversion.
- BLANK_LZ, input, 1, enable leading-zero blanking.
- BLINK_MASK, input, DIGITS, bit i=1 makes digit i blink.
- DP_MASK, input, DIGITS, bit i=1 lights the decimal point on digit i.
- BUSY, output, 1, conversion in progress.
- OVERFLOW, output, 1, displayed value is ≥ 10^DIGITS.
- SEVEN_SEG_OUT, output, 7, segments {g,f,e,d,c,b,a}, registered.
- DP_OUT, output, 1, decimal point, registered.
- anodes, output, DIGITS, digit enables; bit 0 = leftmost (most significant) digit; registered.

Behaviour:
Reset (synchronous, when RESET=1):
- Digit index=0, blink counter=0, blink phase=on.
- Display register=all zero, OVERFLOW=0, BUSY=0, FSM=IDLE, pending flag cleared.
- All anodes inactive, all segments off, DP_OUT off.
- RESET mid-conversion abandons the conversion; the display register still returns to zero.

Conversion FSM, states IDLE → SHIFT → COMMIT → IDLE:
- IDLE: LOAD=1 captures VALUE into the shift register, clears the BCD accumulator, sets BUSY=1 and goes to SHIFT.
- SHIFT: exactly VALUE_W cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd,bin} shifts left by one.
- BCD accumulator width is 4·DIGITS plus enough guard nibbles to hold 2^VALUE_W−1.
- COMMIT: one cycle.
  - Any nonzero guard nibble → OVERFLOW=1; otherwise OVERFLOW=0.
  - Low DIGITS nibbles copy into the display register.
  - BUSY=0 in the cycle after COMMIT.
- Load-to-display-register latency = VALUE_W+2 cycles. The display keeps the old value until COMMIT.
- LOAD while BUSY: VALUE is latched into a pending register (last one wins). On leaving COMMIT the FSM restarts from the pending value with no idle cycle; BUSY stays high.
- LOAD and RESET together: RESET wins.

Scan:
- On TICK the digit index increments and wraps from DIGITS−1 to 0. No TICK means the index holds.
- Outputs register one CLOCK after the index changes. Exactly one anode is active at a time, except for a blanked digit, which drives all anodes inactive for that slot.

Digit content, with d = display nibble for the current index:
- OVERFLOW=1: every digit shows a dash (segment g only). Blanking is ignored; blink and DP still apply.
- Leading-zero blanking (BLANK_LZ=1): digits left of the first nonzero nibble are blanked. Digit DIGITS−1 is never blanked, so value 0 shows as a single "0".
- Blink:
  - The blink counter counts TICKs. At BLINK_DIV−1 it wraps to 0 and toggles the phase.
  - Phase off with BLINK_MASK[i]=1 → digit i is blanked, including its DP.
- A nibble outside 0..9 cannot occur; the decoder's default is all segments off.
- Polarity parameters are applied only at the output register.

Decomposition:
- Shared package seg7_pkg holds:
  - the 7-bit glyph constants for digits 0–9, SEG_DASH and SEG_OFF (active-high form);
  - the FSM state enum.
- One sub-module, seg7_glyph_rom: combinational nibble → active-high glyph. It is instantiated once on the muxed nibble, not once per digit.

Test Plan:
- Reset then LOAD VALUE=1234, BLANK_LZ=0, on 4 TICKs → BUSY high for exactly 16 cycles. Anodes 1110/1101/1011/0111 carry glyphs 1,2,3,4; digit 0 SEVEN_SEG_OUT=7'b1111001.
- LOAD VALUE=7, BLANK_LZ=1 → digits 0–2 have all anodes inactive, digit 3 shows 7'b1111000. Then VALUE=0 → only digit 3 shows 7'b1000000.
- LOAD VALUE=12345 (DIGITS=4) → OVERFLOW=1 and all four digits show 7'b0111111. Then LOAD VALUE=9999 → OVERFLOW=0 and 9999 is shown.
- BLINK_MASK=4'b0011, BLINK_DIV=4, TICK every cycle → digits 0,1 alternately shown and blanked every 4 ticks; digits 2,3 always shown. DP_MASK=4'b0100 → DP_OUT=0 only on digit 2.
- LOAD 1111, then LOAD 2222 at SHIFT cycle 5, then LOAD 3333 at cycle 8 → 1111 commits first, 3333 next, 2222 never appears. BUSY stays high continuously until the second COMMIT.
- RESET asserted mid-SHIFT → next cycle BUSY=0, all anodes inactive, display register 0. Later TICKs show 0000, or "   0" with BLANK_LZ=1.
